// File: rtl/icache_pkg.sv
// Shared state encoding, default geometry and derived constants for the
// instruction-cache data array.
package icache_pkg;

  localparam int LINE_WIDTH_DEF  = 512;
  localparam int ADDR_BITS_DEF   = 5;
  localparam int WAYS_DEF        = 2;
  localparam int FILL_WIDTH_DEF  = 64;
  localparam int INSTR_WIDTH_DEF = 32;

  // Index width that never collapses to zero bits for single-entry dimensions.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BEATS       = LINE_WIDTH_DEF / FILL_WIDTH_DEF;
  localparam int WORDS       = LINE_WIDTH_DEF / INSTR_WIDTH_DEF;
  localparam int OFFSET_BITS = $clog2(WORDS);
  localparam int WAY_BITS    = clog2_min1(WAYS_DEF);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_COMMIT = 2'd2
  } fill_state_e;

endpackage

// File: rtl/icache_way_bank.sv
// One way of the data array: single-port synchronous RAM, one line per set,
// registered read port.
module icache_way_bank
  import icache_pkg::*;
#(
  parameter int WIDTH      = LINE_WIDTH_DEF,
  parameter int DEPTH_BITS = ADDR_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [DEPTH_BITS-1:0] addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] r_mem [2**DEPTH_BITS];
  logic [WIDTH-1:0] r_rdata;

  // NOTE: the storage array is never reset so it maps onto a RAM macro; only the read register is.
  always_ff @(posedge clk) begin
    if (en_i && we_i) r_mem[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst)                r_rdata <= '0;
    else if (en_i && !we_i) r_rdata <= r_mem[addr_i];
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/icache_data_array.sv
// Instruction-cache data array: beat-wise line refill into a line buffer,
// one-cycle commit to the selected way, and 1-cycle-latency word fetch.
module icache_data_array
  import icache_pkg::*;
#(
  parameter int LINE_WIDTH  = LINE_WIDTH_DEF,
  parameter int ADDR_BITS   = ADDR_BITS_DEF,
  parameter int WAYS        = WAYS_DEF,
  parameter int FILL_WIDTH  = FILL_WIDTH_DEF,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          rd_valid_i,
  output logic                                          rd_ready_o,
  input  logic [ADDR_BITS-1:0]                          rd_set_i,
  input  logic [clog2_min1(WAYS)-1:0]                   rd_way_i,
  input  logic [clog2_min1(LINE_WIDTH/INSTR_WIDTH)-1:0] rd_offset_i,
  output logic                                          rd_valid_o,
  output logic [INSTR_WIDTH-1:0]                        rd_data_o,
  input  logic                                          fill_start_i,
  input  logic [ADDR_BITS-1:0]                          fill_set_i,
  input  logic [clog2_min1(WAYS)-1:0]                   fill_way_i,
  input  logic                                          fill_valid_i,
  input  logic [FILL_WIDTH-1:0]                         fill_data_i,
  output logic                                          fill_ready_o,
  output logic                                          fill_done_o,
  output logic                                          busy_o
);

  localparam int N_BEATS = LINE_WIDTH / FILL_WIDTH;
  localparam int OFF_W   = clog2_min1(LINE_WIDTH / INSTR_WIDTH);
  localparam int WAY_W   = clog2_min1(WAYS);
  localparam int BEAT_W  = clog2_min1(N_BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

  fill_state_e           r_state, w_next_state;
  logic [BEAT_W-1:0]     r_beat;
  logic [ADDR_BITS-1:0]  r_fill_set;
  logic [WAY_W-1:0]      r_fill_way;
  logic [LINE_WIDTH-1:0] r_line;
  logic                  r_rd_valid;
  logic [WAY_W-1:0]      r_rd_way;
  logic [OFF_W-1:0]      r_rd_off;
  logic                  w_rd_accept;
  logic                  w_beat_accept;
  logic                  w_commit;
  logic [LINE_WIDTH-1:0] w_rdata [WAYS];
  logic [LINE_WIDTH-1:0] w_rd_line;

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    fill_ready_o = 1'b0;
    fill_done_o  = 1'b0;
    busy_o       = 1'b1;
    rd_ready_o   = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (fill_start_i) w_next_state = ST_FILL;
      end
      ST_FILL: begin
        fill_ready_o = 1'b1;
        if (fill_valid_i && (r_beat == LAST_BEAT)) w_next_state = ST_COMMIT;
      end
      ST_COMMIT: begin
        fill_done_o  = 1'b1;
        rd_ready_o   = 1'b0;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_rd_accept   = rd_valid_i && rd_ready_o;
  assign w_beat_accept = fill_ready_o && fill_valid_i;
  assign w_commit      = fill_done_o;

  // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_beat     <= '0;
      r_rd_valid <= 1'b0;
      r_rd_way   <= '0;
      r_rd_off   <= '0;
    end else begin
      r_state    <= w_next_state;
      r_rd_valid <= w_rd_accept;
      if (w_rd_accept) begin
        r_rd_way <= rd_way_i;
        r_rd_off <= rd_offset_i;
      end
      if (w_beat_accept) r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
    end
  end

  // Target is captured only when a refill actually starts; later starts are ignored.
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && fill_start_i) begin
      r_fill_set <= fill_set_i;
      r_fill_way <= fill_way_i;
    end
    if (w_beat_accept) r_line[r_beat*FILL_WIDTH +: FILL_WIDTH] <= fill_data_i;
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic w_sel_wr;
    logic w_sel_rd;
    assign w_sel_wr = w_commit && (r_fill_way == WAY_W'(w));
    assign w_sel_rd = w_rd_accept && (rd_way_i == WAY_W'(w));

    icache_way_bank #(
      .WIDTH      (LINE_WIDTH),
      .DEPTH_BITS (ADDR_BITS)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .en_i    (w_sel_wr || w_sel_rd),
      .we_i    (w_sel_wr),
      .addr_i  (w_sel_wr ? r_fill_set : rd_set_i),
      .wdata_i (r_line),
      .rdata_o (w_rdata[w])
    );
  end

  // Way/offset registers only move on accepted reads, so the output holds between reads.
  assign w_rd_line  = w_rdata[r_rd_way];
  assign rd_data_o  = w_rd_line[r_rd_off*INSTR_WIDTH +: INSTR_WIDTH];
  assign rd_valid_o = r_rd_valid;

endmodule

// File: doc/icache_data_array.md
ICACHE_DATA_ARRAY -- requirements
Module: icache_data_array

Interface
REQ-001 Parameter LINE_WIDTH, 512, cache line width in bits.
REQ-002 Parameter ADDR_BITS, 5, set index width; 2**ADDR_BITS sets per way.
REQ-003 Parameter WAYS, 2, associativity; power of two, >=1.
REQ-004 Parameter FILL_WIDTH, 64, refill beat width; divides LINE_WIDTH.
REQ-005 Parameter INSTR_WIDTH, 32, fetch word width; divides LINE_WIDTH.
REQ-006 Derived constants: BEATS=LINE_WIDTH/FILL_WIDTH; WORDS=LINE_WIDTH/INSTR_WIDTH; OFFSET_BITS=clog2(WORDS); WAY_BITS=max(1,clog2(WAYS)).
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 rd_valid_i  in  1  fetch read request.
REQ-010 rd_ready_o  out  1  read request accepted this cycle.
REQ-011 rd_set_i  in  ADDR_BITS  set index of read.
REQ-012 rd_way_i  in  WAY_BITS  way of read.
REQ-013 rd_offset_i  in  OFFSET_BITS  word index within line.
REQ-014 rd_valid_o  out  1  read data valid.
REQ-015 rd_data_o  out  INSTR_WIDTH  selected instruction word.
REQ-016 fill_start_i  in  1  begin refill of one line.
REQ-017 fill_set_i  in  ADDR_BITS  refill target set, sampled with fill_start_i.
REQ-018 fill_way_i  in  WAY_BITS  refill target way, sampled with fill_start_i.
REQ-019 fill_valid_i  in  1  refill beat present.
REQ-020 fill_data_i  in  FILL_WIDTH  refill beat data.
REQ-021 fill_ready_o  out  1  beat accepted when fill_valid_i also high.
REQ-022 fill_done_o  out  1  one-cycle pulse: line written to array.
REQ-023 busy_o  out  1  high whenever state is not IDLE.

Function
REQ-024 FSM states IDLE, FILL, COMMIT; IDLE->FILL on fill_start_i; FILL->COMMIT on accepted final beat (count BEATS-1); COMMIT->IDLE unconditionally next cycle.
REQ-025 fill_start_i outside IDLE shall be ignored; target set/way latched only on the IDLE->FILL transition.
REQ-026 fill_ready_o shall be high exactly in FILL; beats with fill_valid_i low shall not advance the beat counter.
REQ-027 Accepted beat k (0..BEATS-1) shall land in line-buffer bits [k*FILL_WIDTH +: FILL_WIDTH]; counter wraps to 0 at COMMIT.
REQ-028 In COMMIT the whole assembled line shall be written to the latched way/set; fill_done_o high in that same cycle only.
REQ-029 rd_ready_o shall be high in IDLE and FILL, low in COMMIT (single-port write cycle).
REQ-030 Accepted read: rd_valid_o high next cycle, rd_data_o = word rd_offset_i of line at (rd_way_i, rd_set_i), bits [rd_offset_i*INSTR_WIDTH +: INSTR_WIDTH]; latency exactly 1.
REQ-031 Read of the line being filled during FILL shall return pre-fill contents; read the cycle after COMMIT shall return new contents.
REQ-032 rd_valid_o low when no read accepted; rd_data_o holds last value.
REQ-033 BEATS=1: FILL lasts one accepted beat then COMMIT.

Reset
REQ-034 rst shall force IDLE, beat counter 0, rd_valid_o 0, rd_data_o 0, fill_ready_o 0, fill_done_o 0, busy_o 0.
REQ-035 rst during FILL shall abort without writing the array; array contents shall not be cleared by reset.

Structure
REQ-036 State enum and derived constants (BEATS, WORDS, OFFSET_BITS, WAY_BITS) shall live in shared package icache_pkg.
REQ-037 Storage shall be WAYS instances of sub-module icache_way_bank (single-port synchronous RAM, LINE_WIDTH x 2**ADDR_BITS, registered read).

Verification
REQ-038 Fill way 1 set 3 with 8 beats 64'h0..0k..k, read offsets 0,15 -> rd_data_o 32'h00000000 / 32'h77777777, latency 1, fill_done_o single pulse.
REQ-039 Fill with fill_valid_i gapped every other cycle -> exactly 8 beats accepted, COMMIT only after 8th.
REQ-040 Read set 3 way 1 during FILL -> old data; read in COMMIT cycle -> rd_ready_o 0; read next cycle -> new data.
REQ-041 fill_start_i pulsed during FILL with set 5 -> ignored, line written to original set 3, set 5 unchanged.
REQ-042 rst asserted after beat 4 -> busy_o 0 next cycle, set 3 retains prior contents, subsequent fill completes normally.
REQ-043 Back-to-back fills way 0 and way 1 same set -> both lines independently readable, no cross-way corruption.
